// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and issue bundle of the ALU reservation station.
// master: decoder/CDB/ALU side; slave: the station.
interface alu_reservation_station_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 5
);
  localparam int PKT_W = OP_W + 3*TAG_W + 2*DATA_W;

  logic              enALU;
  logic [PKT_W-1:0]  aluData;
  logic              full;
  logic              flush;
  logic              cdbValid;
  logic [TAG_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;
  logic              aluEn;
  logic [OP_W-1:0]   aluOp;
  logic [DATA_W-1:0] aluSrc1;
  logic [DATA_W-1:0] aluSrc2;
  logic [TAG_W-1:0]  aluDestTag;

  modport master (
    output enALU, aluData, flush,
    output cdbValid, cdbTag, cdbData,
    input  full, aluEn, aluOp,
    input  aluSrc1, aluSrc2, aluDestTag
  );

  modport slave (
    input  enALU, aluData, flush,
    input  cdbValid, cdbTag, cdbData,
    output full, aluEn, aluOp,
    output aluSrc1, aluSrc2, aluDestTag
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers DEPTH ops, snoops the CDB, issues one
// ready op per cycle. Ports: clk, rst (async active-low), bus (slave).
module alu_reservation_station #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 5,
  parameter int DEPTH    = 4,
  parameter int TAG_FREE = 0
) (
  input  logic clk,
  input  logic rst,
  alu_reservation_station_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] FREE = TAG_W'(TAG_FREE);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] data1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] data2;
    logic [TAG_W-1:0]  dst;
  } ent_t;

  ent_t              ent [DEPTH];
  logic [DEPTH-1:0]  vld;
  ent_t              pkt;
  logic              is_full;

  logic              cdb_v;
  logic [TAG_W-1:0]  cdb_t;
  logic [DATA_W-1:0] cdb_d;

  logic              alloc_hit;
  logic [IW-1:0]     alloc_idx;
  logic              iss_hit;
  logic [IW-1:0]     iss_idx;

  logic              en_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [TAG_W-1:0]  dst_q;

  assign pkt     = ent_t'(bus.aluData);
  assign cdb_v   = bus.cdbValid;
  assign cdb_t   = bus.cdbTag;
  assign cdb_d   = bus.cdbData;
  assign is_full = &vld;

  assign bus.full       = is_full;
  assign bus.aluEn      = en_q;
  assign bus.aluOp      = op_q;
  assign bus.aluSrc1    = src1_q;
  assign bus.aluSrc2    = src2_q;
  assign bus.aluDestTag = dst_q;

  function automatic logic hit(input logic [TAG_W-1:0] t);
    return cdb_v && (t != FREE) && (t == cdb_t);
  endfunction

  // Applies a CDB capture to both operands; also used on the incoming
  // packet so a same-cycle broadcast is never missed.
  function automatic ent_t snoop(input ent_t e);
    ent_t r;
    r = e;
    if (hit(e.tag1)) begin
      r.data1 = cdb_d;
      r.tag1  = FREE;
    end
    if (hit(e.tag2)) begin
      r.data2 = cdb_d;
      r.tag2  = FREE;
    end
    return r;
  endfunction

  // Downward scans leave the lowest matching index selected.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    iss_hit   = 1'b0;
    iss_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = IW'(i);
      end
      if (vld[i] && ent[i].tag1 == FREE &&
          ent[i].tag2 == FREE) begin
        iss_hit = 1'b1;
        iss_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      en_q   <= 1'b0;
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      dst_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (bus.flush) begin
      vld  <= '0;
      en_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i]) begin
          ent[i] <= snoop(ent[i]);
        end
      end
      if (iss_hit) begin
        vld[iss_idx] <= 1'b0;
        en_q   <= 1'b1;
        op_q   <= ent[iss_idx].op;
        src1_q <= ent[iss_idx].data1;
        src2_q <= ent[iss_idx].data2;
        dst_q  <= ent[iss_idx].dst;
      end else begin
        en_q <= 1'b0;
      end
      // Issued slot was valid pre-edge, so it never aliases alloc_idx.
      if (bus.enALU && !is_full && alloc_hit) begin
        vld[alloc_idx] <= 1'b1;
        ent[alloc_idx] <= snoop(pkt);
      end
    end
  end

endmodule
